// File: rtl/obj_spawn_scheduler_pkg.sv
// Shared types and constants for the object spawn scheduler: FSM encoding,
// identity codes, spawn-range defaults and the queued request layout.
package obj_spawn_scheduler_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_ISSUE = 2'd2
  } state_t;

  localparam logic [1:0] ID_COLLECT = 2'd0;
  localparam logic [1:0] ID_HAZARD  = 2'd1;

  localparam int unsigned VPOS_MIN_DEFAULT = 230;
  localparam int unsigned VPOS_MAX_DEFAULT = 485;

  localparam int unsigned ENTRY_W = 14;

  // src is one-hot {midi, rnd}; it travels with the entry as a debug tag.
  typedef struct packed {
    logic [1:0] src;
    logic [1:0] id;
    logic [9:0] vpos;
  } spawn_req_t;

  function automatic logic [9:0] clamp_vpos(input logic [9:0] v,
                                            input logic [9:0] lo,
                                            input logic [9:0] hi);
    if (v < lo) return lo;
    if (v > hi) return hi;
    return v;
  endfunction

endpackage

// File: rtl/obj_spawn_scheduler_spawn_fifo.sv
// Synchronous FIFO holding pending spawn requests, with occupancy count and
// a synchronous flush used when the game leaves PLAY.
module spawn_fifo #(
  parameter  int DEPTH = 4,
  parameter  int WIDTH = 14,
  localparam int CW    = $clog2(DEPTH + 1),
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  function automatic logic [AW-1:0] ptr_next(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  assign do_push = push && (count != CW'(DEPTH));
  assign do_pop  = pop && (count != '0);
  assign rdata   = mem[rd_ptr];

  // NOTE: state registers use <= so every flop samples pre-edge values.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_next(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_next(rd_ptr);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  // NOTE: storage is not reset; count gates every read of a valid entry.
  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/obj_spawn_scheduler.sv
// Arbitrates random and MIDI spawn requests into a FIFO and issues them, one
// per frame tick, into the lowest free object slot subject to a cooldown.
module obj_spawn_scheduler
  import obj_spawn_scheduler_pkg::*;
#(
  parameter int NUM_SLOTS  = 5,
  parameter int FIFO_DEPTH = 4,
  parameter int MIN_GAP    = 8,
  parameter int VPOS_MIN   = VPOS_MIN_DEFAULT,
  parameter int VPOS_MAX   = VPOS_MAX_DEFAULT
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 enable,
  input  logic                 frame_tick,
  input  logic [NUM_SLOTS-1:0] slot_busy,
  input  logic                 rnd_valid,
  output logic                 rnd_ready,
  input  logic [1:0]           rnd_id,
  input  logic [9:0]           rnd_vpos,
  input  logic                 midi_valid,
  output logic                 midi_ready,
  input  logic [1:0]           midi_id,
  input  logic [9:0]           midi_vpos,
  output logic                 spawn_valid,
  output logic [2:0]           spawn_slot,
  output logic [1:0]           spawn_id,
  output logic [9:0]           spawn_vpos,
  output logic [2:0]           pending,
  output logic [7:0]           dropped
);

  localparam int         CW       = $clog2(FIFO_DEPTH + 1);
  localparam logic [9:0] VMIN     = 10'(VPOS_MIN);
  localparam logic [9:0] VMAX     = 10'(VPOS_MAX);
  localparam logic [7:0] GAP_LOAD = 8'(MIN_GAP - 1);

  state_t               state, state_nx;
  logic [CW-1:0]        count;
  logic                 rr_ptr, can_accept, contested, push;
  logic                 pop, do_issue, do_drop, has_free;
  logic [2:0]           free_idx;
  logic [NUM_SLOTS-1:0] free_slots, reserved, res_age, busy_q;
  logic [7:0]           cooldown;
  spawn_req_t           wr_req, head;
  logic [1:0]           unused_src;

  // Readiness comes from registered occupancy only, never from this cycle's pop.
  assign can_accept = enable && !reset && (count < CW'(FIFO_DEPTH));
  assign contested  = rnd_valid && midi_valid;
  assign rnd_ready  = can_accept && !(contested && rr_ptr);
  assign midi_ready = can_accept && !(contested && !rr_ptr);
  assign push       = (rnd_valid && rnd_ready) || (midi_valid && midi_ready);

  assign spawn_valid = (state == ST_ISSUE) && enable;
  assign pending     = 3'(count);
  assign unused_src  = head.src;

  // NOTE: every always_comb output gets a default first, so no latches form.
  always_comb begin
    wr_req = '0;
    if (rnd_valid && rnd_ready) begin
      wr_req.src  = 2'b01;
      wr_req.id   = rnd_id;
      wr_req.vpos = clamp_vpos(rnd_vpos, VMIN, VMAX);
    end else if (midi_valid && midi_ready) begin
      wr_req.src  = 2'b10;
      wr_req.id   = midi_id;
      wr_req.vpos = clamp_vpos(midi_vpos, VMIN, VMAX);
    end
  end

  always_comb begin
    free_slots = ~slot_busy & ~reserved;
    has_free   = |free_slots;
    free_idx   = '0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (free_slots[i]) free_idx = 3'(i);
    end
  end

  spawn_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(ENTRY_W)) u_fifo (
    .clock (clock),
    .reset (reset),
    .flush (!enable),
    .push  (push),
    .pop   (pop),
    .wdata (wr_req),
    .rdata (head),
    .count (count)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    pop      = 1'b0;
    do_issue = 1'b0;
    do_drop  = 1'b0;
    unique case (state)
      ST_IDLE: if (push) state_nx = ST_WAIT;
      ST_WAIT: begin
        if (frame_tick && (cooldown == '0)) begin
          pop = 1'b1;
          if (has_free) begin
            do_issue = 1'b1;
            state_nx = ST_ISSUE;
          end else begin
            do_drop = 1'b1;
            if ((count == CW'(1)) && !push) state_nx = ST_IDLE;
          end
        end
      end
      ST_ISSUE: state_nx = ((count != '0) || push) ? ST_WAIT : ST_IDLE;
      default:  state_nx = ST_IDLE;
    endcase
    if (!enable) begin
      state_nx = ST_IDLE;
      pop      = 1'b0;
      do_issue = 1'b0;
      do_drop  = 1'b0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rr_ptr     <= 1'b0;
      busy_q     <= '0;
      dropped    <= '0;
      spawn_slot <= '0;
      spawn_id   <= '0;
      spawn_vpos <= '0;
    end else begin
      busy_q <= slot_busy;
      if (push && contested) rr_ptr <= !rr_ptr;
      if (do_drop && (dropped != 8'hFF)) dropped <= dropped + 8'd1;
      if (do_issue) begin
        spawn_slot <= free_idx;
        spawn_id   <= head.id;
        spawn_vpos <= head.vpos;
      end
    end
  end

  // A reservation covers the gap between issue and the object claiming its slot.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cooldown <= '0;
      reserved <= '0;
      res_age  <= '0;
    end else if (!enable) begin
      cooldown <= '0;
      reserved <= '0;
      res_age  <= '0;
    end else begin
      if (do_issue)                          cooldown <= GAP_LOAD;
      else if (frame_tick && cooldown != '0) cooldown <= cooldown - 8'd1;
      for (int i = 0; i < NUM_SLOTS; i++) begin
        if (do_issue && (free_idx == 3'(i))) begin
          reserved[i] <= 1'b1;
          res_age[i]  <= 1'b0;
        end else if (reserved[i] && slot_busy[i] && !busy_q[i]) begin
          reserved[i] <= 1'b0;
        end else if (reserved[i] && frame_tick) begin
          if (res_age[i]) reserved[i] <= 1'b0;
          else            res_age[i]  <= 1'b1;
        end
      end
    end
  end

endmodule

// File: doc/obj_spawn_scheduler.md
OBJ_SPAWN_SCHEDULER -- requirements
Module: obj_spawn_scheduler

Interface
REQ-001 Parameter NUM_SLOTS, default 5: number of on-screen object slots.
REQ-002 Parameter FIFO_DEPTH, default 4: pending spawn-request entries.
REQ-003 Parameter MIN_GAP, default 8: minimum frame ticks between two spawns.
REQ-004 Parameter VPOS_MIN, default 230; VPOS_MAX, default 485: legal spawn vertical range.
REQ-005 clock  in  1: single system clock; all state on its rising edge.
REQ-006 reset  in  1: asynchronous, active-high reset.
REQ-007 enable  in  1: game in PLAY; low flushes the block and blocks all activity.
REQ-008 frame_tick  in  1: one-cycle pulse per video frame (vsync edge).
REQ-009 slot_busy  in  NUM_SLOTS: bit i high when object slot i is occupied.
REQ-010 rnd_valid / rnd_ready  in / out  1: random-spawner request handshake.
REQ-011 rnd_id, rnd_vpos  in  2 / 10: identity (0 collectable, 1 hazard) and vertical position.
REQ-012 midi_valid / midi_ready  in / out  1: note-driven request handshake.
REQ-013 midi_id, midi_vpos  in  2 / 10: as REQ-011.
REQ-014 spawn_valid  out  1: one-cycle spawn command.
REQ-015 spawn_slot, spawn_id, spawn_vpos  out  3 / 2 / 10: target slot, identity, clamped vpos.
REQ-016 pending  out  3: current FIFO occupancy.
REQ-017 dropped  out  8: saturating count of requests discarded at issue time.

Function
REQ-018 Request accepted when valid and ready high in same cycle; ready = enable and registered occupancy < FIFO_DEPTH.
REQ-019 At most one enqueue per cycle; when both requesters valid, round-robin pointer selects winner, loser's ready low that cycle; pointer toggles after each contested grant; reset value selects rnd.
REQ-020 vpos clamped to [VPOS_MIN, VPOS_MAX] on enqueue; id stored unchanged.
REQ-021 FSM states: IDLE (FIFO empty), WAIT (non-empty, awaiting issue), ISSUE (spawn_valid high one cycle).
REQ-022 IDLE->WAIT on enqueue; WAIT->ISSUE on frame_tick when cooldown = 0 and a free slot exists; ISSUE->WAIT if FIFO still non-empty, else IDLE.
REQ-023 Issue latency: frame_tick in cycle N -> spawn_valid in cycle N+1.
REQ-024 Free slot = ~slot_busy & ~reserved; chosen slot is lowest-index free bit.
REQ-025 On issue the slot's reserved bit sets; it clears when slot_busy for that slot rises or after 2 frame_ticks, whichever first.
REQ-026 On frame_tick in WAIT with cooldown = 0 and no free slot, head entry popped and discarded, dropped increments (saturates at 255), no spawn_valid.
REQ-027 Cooldown loads MIN_GAP-1 on issue, decrements per frame_tick, floors at 0.
REQ-028 Enqueue and dequeue in same cycle allowed; occupancy unchanged; ready still from registered occupancy.
REQ-029 enable low: FIFO, reservations, cooldown cleared, state IDLE, readies low, spawn_valid low; dropped held.
REQ-030 spawn_slot/id/vpos hold last issued values when spawn_valid low.

Reset
REQ-031 Reset clears FIFO, pointers, reservations, cooldown, round-robin pointer, dropped; state IDLE.
REQ-032 All outputs 0 during and immediately after reset, including mid-ISSUE.

Structure
REQ-033 Shared package holds FSM state encoding, identity codes (COLLECT=0, HAZARD=1), VPOS_MIN/VPOS_MAX defaults.
REQ-034 One sub-module, spawn_fifo (synchronous FIFO, depth FIFO_DEPTH, 14-bit entries, count output).

Verification
REQ-035 Single rnd request id=1 vpos=100, slot_busy=0, then frame_tick -> spawn_valid next cycle, slot 0, id 1, vpos 230.
REQ-036 rnd and midi valid together three cycles -> grants alternate rnd, midi, rnd; pending = 3.
REQ-037 Five requests with FIFO_DEPTH=4 -> fifth sees ready low until a dequeue; pending never exceeds 4.
REQ-038 slot_busy=5'b11111, one queued request, frame_tick -> no spawn_valid, dropped = 1, pending = 0.
REQ-039 Two queued, slot_busy=0 -> first spawn slot 0, second not issued before 8th subsequent frame_tick, then slot 1 (slot 0 still reserved) or slot 0 if reservation expired and busy low.
REQ-040 Reset asserted in ISSUE cycle with pending=3 -> spawn_valid, pending, dropped all 0 immediately; readies high after reset with enable high.
